// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: game state codes, piece codes and board geometry.
// The pixel colour generator decodes the same state codes from this package.
package tetris_pkg;

   typedef enum logic [2:0] {
      START_SCREEN  = 3'b000,
      COUNTING      = 3'b001,
      START_FALLING = 3'b010,
      FALLING       = 3'b011,
      DISTROY_LINE  = 3'b101,
      FAIL          = 3'b111
   } game_state_t;

   typedef enum logic [1:0] {
      PH_DRAW,
      PH_SPAWN,
      PH_CHECK
   } spawn_phase_t;

   localparam logic [2:0] PIECE_NONE = 3'b000;
   localparam logic [2:0] PIECE_T    = 3'b001;
   localparam logic [2:0] PIECE_O    = 3'b010;
   localparam logic [2:0] PIECE_L    = 3'b011;
   localparam logic [2:0] PIECE_J    = 3'b100;
   localparam logic [2:0] PIECE_S    = 3'b101;
   localparam logic [2:0] PIECE_Z    = 3'b110;
   localparam logic [2:0] PIECE_I    = 3'b111;

   localparam int BOARD_COLS = 10;
   localparam int BOARD_ROWS = 20;

   localparam logic [9:0] LINES_MAX   = 10'd999;
   localparam logic [1:0] COUNT_START = 2'd3;

endpackage

// File: rtl/piece_rng.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) that offers a piece
// draw whenever its low three bits are a legal, non-zero piece code.
module piece_rng
   import tetris_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   output logic       valid,
   output logic [2:0] piece
);

   logic [15:0] lfsr;
   logic        feedback;

   assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   // Keeps stepping regardless of game state so draw timing depends on play.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= SEED;
      end else begin
         lfsr <= {lfsr[14:0], feedback};
      end
   end

   assign piece = lfsr[2:0];
   assign valid = req && (piece != PIECE_NONE);

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: countdown, piece selection, gravity pacing and the
// hand-offs to the piece engine and the line-clear engine.
module game_sequencer
   import tetris_pkg::*;
#(
   parameter int          COUNT_FRAMES = 60,
   parameter int          FALL_FRAMES  = 30,
   parameter int          DROP_FRAMES  = 2,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       start_btn,
   input  logic       soft_drop,
   input  logic       spawn_blocked,
   input  logic       landed,
   input  logic       row_full,
   input  logic       clear_done,
   output logic [2:0] q,
   output logic [1:0] q_counting,
   output logic [2:0] block,
   output logic [2:0] next_block,
   output logic       spawn,
   output logic       fall_tick,
   output logic       clear_start,
   output logic [9:0] lines
);

   localparam logic [15:0] COUNT_LIMIT = 16'(COUNT_FRAMES);
   localparam logic [15:0] FALL_LIMIT  = 16'(FALL_FRAMES);
   localparam logic [15:0] DROP_LIMIT  = 16'(DROP_FRAMES);

   game_state_t  state, state_nxt;
   spawn_phase_t phase, phase_nxt;
   logic [1:0]   digit_nxt;
   logic [2:0]   block_nxt, next_block_nxt;
   logic         spawn_nxt, fall_tick_nxt, clear_start_nxt;
   logic [9:0]   lines_nxt;
   logic [15:0]  frame_cnt, frame_cnt_nxt;
   logic [15:0]  fall_cnt, fall_cnt_nxt, fall_limit;
   logic         btn_prev, start_rise;
   logic         preview_pending, pending_nxt;
   logic         rng_req, rng_valid;
   logic [2:0]   rng_piece;

   assign q          = state;
   assign start_rise = start_btn & ~btn_prev;
   assign fall_limit = soft_drop ? DROP_LIMIT : FALL_LIMIT;

   // A preview draw that hit 000 at game start keeps retrying during the countdown.
   assign rng_req = (state == START_SCREEN  && start_rise) ||
                    (state == COUNTING      && preview_pending) ||
                    (state == START_FALLING && phase == PH_DRAW);

   piece_rng #(
      .SEED(LFSR_SEED)
   ) u_rng (
      .clk  (clk),
      .rst  (rst),
      .req  (rng_req),
      .valid(rng_valid),
      .piece(rng_piece)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= START_SCREEN;
         phase           <= PH_DRAW;
         q_counting      <= COUNT_START;
         block           <= PIECE_T;
         next_block      <= PIECE_I;
         spawn           <= 1'b0;
         fall_tick       <= 1'b0;
         clear_start     <= 1'b0;
         lines           <= '0;
         frame_cnt       <= '0;
         fall_cnt        <= '0;
         btn_prev        <= 1'b1;
         preview_pending <= 1'b0;
      end else begin
         state           <= state_nxt;
         phase           <= phase_nxt;
         q_counting      <= digit_nxt;
         block           <= block_nxt;
         next_block      <= next_block_nxt;
         spawn           <= spawn_nxt;
         fall_tick       <= fall_tick_nxt;
         clear_start     <= clear_start_nxt;
         lines           <= lines_nxt;
         frame_cnt       <= frame_cnt_nxt;
         fall_cnt        <= fall_cnt_nxt;
         btn_prev        <= start_btn;
         preview_pending <= pending_nxt;
      end
   end

   // Pulses default low so each one lasts exactly the cycle after its cause.
   always_comb begin
      state_nxt       = state;
      phase_nxt       = phase;
      digit_nxt       = q_counting;
      block_nxt       = block;
      next_block_nxt  = next_block;
      spawn_nxt       = 1'b0;
      fall_tick_nxt   = 1'b0;
      clear_start_nxt = 1'b0;
      lines_nxt       = lines;
      frame_cnt_nxt   = frame_cnt;
      fall_cnt_nxt    = fall_cnt;
      pending_nxt     = preview_pending;

      case (state)
         START_SCREEN: begin
            if (start_rise) begin
               state_nxt     = COUNTING;
               lines_nxt     = '0;
               digit_nxt     = COUNT_START;
               frame_cnt_nxt = frame_tick ? 16'd1 : 16'd0;
               if (rng_valid) begin
                  next_block_nxt = rng_piece;
               end else begin
                  pending_nxt = 1'b1;
               end
            end
         end

         COUNTING: begin
            if (rng_valid) begin
               next_block_nxt = rng_piece;
               pending_nxt    = 1'b0;
            end
            if (frame_tick) begin
               if (frame_cnt + 16'd1 >= COUNT_LIMIT) begin
                  frame_cnt_nxt = '0;
                  if (q_counting == 2'd1) begin
                     state_nxt = START_FALLING;
                  end else begin
                     digit_nxt = q_counting - 2'd1;
                  end
               end else begin
                  frame_cnt_nxt = frame_cnt + 16'd1;
               end
            end
         end

         START_FALLING: begin
            case (phase)
               PH_DRAW: begin
                  if (rng_valid) begin
                     block_nxt      = next_block;
                     next_block_nxt = rng_piece;
                     spawn_nxt      = 1'b1;
                     pending_nxt    = 1'b0;
                     phase_nxt      = PH_SPAWN;
                  end
               end
               PH_SPAWN: phase_nxt = PH_CHECK;
               PH_CHECK: begin
                  phase_nxt = PH_DRAW;
                  if (spawn_blocked) begin
                     state_nxt = FAIL;
                  end else begin
                     state_nxt    = FALLING;
                     fall_cnt_nxt = frame_tick ? 16'd1 : 16'd0;
                  end
               end
               default: phase_nxt = PH_DRAW;
            endcase
         end

         FALLING: begin
            if (landed) begin
               if (row_full) begin
                  clear_start_nxt = 1'b1;
                  state_nxt       = DISTROY_LINE;
               end else begin
                  state_nxt = START_FALLING;
               end
            end else if (frame_tick) begin
               if (fall_cnt + 16'd1 >= fall_limit) begin
                  fall_tick_nxt = 1'b1;
                  fall_cnt_nxt  = '0;
               end else begin
                  fall_cnt_nxt = fall_cnt + 16'd1;
               end
            end
         end

         DISTROY_LINE: begin
            if (clear_done) begin
               lines_nxt = (lines >= LINES_MAX) ? LINES_MAX : lines + 10'd1;
               if (row_full) begin
                  clear_start_nxt = 1'b1;
               end else begin
                  state_nxt = START_FALLING;
               end
            end
         end

         FAIL: begin
            if (start_rise) begin
               state_nxt = START_SCREEN;
            end
         end

         default: state_nxt = START_SCREEN;
      endcase
   end

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed game scenarios plus randomized play, all
// checked cycle by cycle against a behavioural model of the game rules.
module tb_game_sequencer;

   localparam int COUNT_F = 60;
   localparam int FALL_F  = 30;
   localparam int DROP_F  = 2;
   localparam int SEED    = 'hACE1;

   localparam int S_START = 0;
   localparam int S_COUNT = 1;
   localparam int S_SPAWN = 2;
   localparam int S_FALL  = 3;
   localparam int S_CLEAR = 5;
   localparam int S_OVER  = 7;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_tick = 1'b0;
   logic       start_btn = 1'b1;
   logic       soft_drop = 1'b0;
   logic       spawn_blocked = 1'b0;
   logic       landed = 1'b0;
   logic       row_full = 1'b0;
   logic       clear_done = 1'b0;
   logic [2:0] q;
   logic [1:0] q_counting;
   logic [2:0] block;
   logic [2:0] next_block;
   logic       spawn;
   logic       fall_tick;
   logic       clear_start;
   logic [9:0] lines;

   game_sequencer #(
      .COUNT_FRAMES(COUNT_F),
      .FALL_FRAMES (FALL_F),
      .DROP_FRAMES (DROP_F),
      .LFSR_SEED   (16'hACE1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .frame_tick   (frame_tick),
      .start_btn    (start_btn),
      .soft_drop    (soft_drop),
      .spawn_blocked(spawn_blocked),
      .landed       (landed),
      .row_full     (row_full),
      .clear_done   (clear_done),
      .q            (q),
      .q_counting   (q_counting),
      .block        (block),
      .next_block   (next_block),
      .spawn        (spawn),
      .fall_tick    (fall_tick),
      .clear_start  (clear_start),
      .lines        (lines)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int draws  = 0;

   // Reference model of the game rules.
   int m_state, m_digit, m_block, m_next, m_lines, m_lfsr;
   int m_frames, m_fall, m_spawn_age;
   bit m_pending, m_prev, m_spawn, m_ftick, m_clear;

   function automatic int lfsrNext(input int v);
      int fb;
      fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
      return ((v << 1) | fb) & 'hFFFF;
   endfunction

   task automatic finishRun();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
         if (errors >= 50) finishRun();
      end
   endtask

   // Advances the model by one clock using the inputs currently driven.
   task automatic modelStep();
      bit rise;
      int cand;
      if (rst) begin
         m_state = S_START; m_digit = 3; m_block = 1; m_next = 7; m_lines = 0;
         m_lfsr = SEED; m_frames = 0; m_fall = 0; m_spawn_age = 0;
         m_pending = 0; m_prev = 1; m_spawn = 0; m_ftick = 0; m_clear = 0;
         return;
      end
      rise = start_btn && !m_prev;
      cand = m_lfsr & 7;
      m_spawn = 0; m_ftick = 0; m_clear = 0;
      case (m_state)
         S_START: if (rise) begin
            m_state = S_COUNT; m_lines = 0; m_digit = 3;
            m_frames = frame_tick ? 1 : 0;
            if (cand != 0) m_next = cand; else m_pending = 1;
         end
         S_COUNT: begin
            if (m_pending && cand != 0) begin m_next = cand; m_pending = 0; end
            if (frame_tick) begin
               m_frames++;
               if (m_frames == COUNT_F) begin
                  m_frames = 0;
                  if (m_digit == 1) m_state = S_SPAWN; else m_digit--;
               end
            end
         end
         S_SPAWN: begin
            if (m_spawn_age == 0) begin
               if (cand != 0) begin
                  m_block = m_next; m_next = cand; m_spawn = 1; m_pending = 0;
                  m_spawn_age = 1;
               end
            end else if (m_spawn_age == 1) begin
               m_spawn_age = 2;
            end else begin
               m_spawn_age = 0;
               if (spawn_blocked) m_state = S_OVER;
               else begin m_state = S_FALL; m_fall = frame_tick ? 1 : 0; end
            end
         end
         S_FALL: begin
            if (landed) begin
               if (row_full) begin m_clear = 1; m_state = S_CLEAR; end
               else m_state = S_SPAWN;
            end else if (frame_tick) begin
               m_fall++;
               if (m_fall >= (soft_drop ? DROP_F : FALL_F)) begin m_ftick = 1; m_fall = 0; end
            end
         end
         S_CLEAR: if (clear_done) begin
            if (m_lines < 999) m_lines++;
            if (row_full) m_clear = 1; else m_state = S_SPAWN;
         end
         S_OVER: if (rise) m_state = S_START;
         default: m_state = S_START;
      endcase
      m_prev = start_btn;
      m_lfsr = lfsrNext(m_lfsr);
   endtask

   task automatic compareAll();
      checkOutput("q", q, m_state);
      checkOutput("q_counting", q_counting, m_digit);
      checkOutput("block", block, m_block);
      checkOutput("next_block", next_block, m_next);
      checkOutput("spawn", spawn, m_spawn);
      checkOutput("fall_tick", fall_tick, m_ftick);
      checkOutput("clear_start", clear_start, m_clear);
      checkOutput("lines", lines, m_lines);
   endtask

   task automatic applyStimulus(input bit ft, input bit btn, input bit sd, input bit sb,
                                input bit lnd, input bit rf, input bit cd, input bit rs);
      frame_tick = ft; start_btn = btn; soft_drop = sd; spawn_blocked = sb;
      landed = lnd; row_full = rf; clear_done = cd; rst = rs;
      modelStep();
      @(posedge clk);
      #1;
      compareAll();
      if (spawn) begin
         draws++;
         checkOutput("draw_nonzero", (next_block != 3'b000), 1);
      end
   endtask

   task automatic checkResetValues();
      checkOutput("rst_q", q, 0);
      checkOutput("rst_q_counting", q_counting, 3);
      checkOutput("rst_block", block, 1);
      checkOutput("rst_next_block", next_block, 7);
      checkOutput("rst_spawn", spawn, 0);
      checkOutput("rst_fall_tick", fall_tick, 0);
      checkOutput("rst_clear_start", clear_start, 0);
      checkOutput("rst_lines", lines, 0);
   endtask

   task automatic countdown(output int saved_next);
      saved_next = 0;
      for (int k = 1; k <= 3 * COUNT_F; k++) begin
         applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
         if (k == COUNT_F) checkOutput("digit_after_60", q_counting, 2);
         if (k == 2 * COUNT_F) checkOutput("digit_after_120", q_counting, 1);
         if (k == 3 * COUNT_F) begin
            checkOutput("q_after_180", q, S_SPAWN);
            saved_next = next_block;
         end else begin
            checkOutput("still_counting", q, S_COUNT);
            applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
         end
      end
   endtask

   task automatic startGame(output int saved_next);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("start_q", q, S_COUNT);
      checkOutput("start_digit", q_counting, 3);
      countdown(saved_next);
   endtask

   task automatic waitFalling(output int spawns);
      spawns = 0;
      for (int i = 0; i < 40 && m_state != S_FALL; i++) begin
         applyStimulus(0, start_btn, soft_drop, 0, 0, 0, 0, 0);
         if (spawn) spawns++;
      end
      checkOutput("reach_falling", q, S_FALL);
   endtask

   initial begin
      int saved;
      int spawns;
      bit ft, btn, sd, sb, lnd, rf, cd, rs;

      $display("[TB] game_sequencer bench starting");
      // Button held high through reset must not start a game.
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 1);
      checkResetValues();
      for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("held_through_reset", q, S_START);

      startGame(saved);
      waitFalling(spawns);
      checkOutput("one_spawn", spawns, 1);
      checkOutput("block_is_prev_next", block, saved);

      // Normal gravity, then soft drop raised at count 10.
      for (int k = 1; k <= 70; k++) begin
         applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
         checkOutput("fall_normal", fall_tick, (k % FALL_F == 0));
         applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
      end
      applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
      for (int j = 1; j <= 6; j++) begin
         applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
         checkOutput("fall_drop", fall_tick, j % 2);
         applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
      end
      applyStimulus(1, 1, 1, 0, 1, 1, 0, 0);
      checkOutput("land_beats_tick", fall_tick, 0);
      checkOutput("clear_on_land", clear_start, 1);
      checkOutput("q_destroy", q, S_CLEAR);

      for (int c = 1; c <= 3; c++) begin
         applyStimulus(0, 1, 0, 0, 0, 1, 0, 0);
         applyStimulus(0, 1, 0, 0, 0, (c < 3), 1, 0);
         checkOutput("lines_count", lines, c);
         checkOutput("clear_repulse", clear_start, (c < 3));
      end
      checkOutput("back_to_spawn", q, S_SPAWN);

      for (int i = 0; i < 20 && m_state != S_OVER; i++) applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
      checkOutput("blocked_to_over", q, S_OVER);
      for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0, 1, 1, 1, 0);
      checkOutput("held_no_restart", q, S_OVER);
      checkOutput("over_lines_hold", lines, 3);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("restart_screen", q, S_START);

      // Second game drives the line counter into saturation, then resets mid-play.
      startGame(saved);
      waitFalling(spawns);
      applyStimulus(0, 1, 0, 0, 1, 1, 0, 0);
      for (int i = 1; i <= 1001; i++) begin
         applyStimulus(0, 1, 0, 0, 0, 1, 1, 0);
         applyStimulus(0, 1, 0, 0, 0, 1, 0, 0);
      end
      checkOutput("lines_saturate", lines, 999);
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 0);
      checkOutput("lines_stay", lines, 999);
      waitFalling(spawns);
      applyStimulus(1, 1, 0, 0, 1, 1, 0, 1);
      checkResetValues();

      // Randomized play with inputs loosely shaped by the modelled state.
      btn = 1; sd = 0;
      for (int n = 0; n < 25000; n++) begin
         if ($urandom_range(0, 7) == 0) btn = !btn;
         if ($urandom_range(0, 15) == 0) sd = !sd;
         ft  = ($urandom_range(0, 2) == 0);
         sb  = ($urandom_range(0, 99) == 0);
         lnd = (m_state == S_FALL) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
         rf  = ($urandom_range(0, 2) == 0);
         cd  = ($urandom_range(0, 2) == 0);
         rs  = ($urandom_range(0, 3999) == 0);
         applyStimulus(ft, btn, sd, sb, lnd, rf, cd, rs);
      end
      checkOutput("enough_draws", (draws > 100), 1);

      finishRun();
   end

endmodule
